// File: rtl/mem_stage_pkg.sv
// Shared RV32I pipeline types used by the MEM stage: packet layout, funct3 encodings
// and the MEM stage state encoding.
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_stage_state_t;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef struct packed {
    logic [31:0] word;
    logic        trap;
  } inst_t;

  typedef struct packed {
    logic       mem;
    logic       data_mem_read;
    logic       data_mem_write;
    logic [2:0] funct3;
    logic       regf_we;
    logic [4:0] rd;
  } ctrl_t;

  typedef struct packed {
    inst_t       inst;
    ctrl_t       ctrl;
    logic [31:0] pc;
    logic [31:0] rs1_out;
    logic [31:0] rs2_out;
    logic [31:0] alu_out;
    logic        br_en;
    logic [31:0] mem_addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mdrreg_out;
  } rv32i_packet_t;

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane logic for the MEM stage: byte masks, store-data lane shift,
// load-data extraction/extension and misalignment detection.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  rmask_o,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] mdr_o,
  output logic        misaligned_o
);

  logic [3:0]  base_mask;
  logic [3:0]  lane_mask;
  logic [31:0] rdata_shifted;
  logic [31:0] extended;

  // Lanes past byte 3 fall off the 4-bit mask, so misaligned accesses only touch in-word bytes.
  always_comb begin
    base_mask    = 4'b1111;
    misaligned_o = 1'b0;
    case (store_funct3_t'({1'b0, funct3_i[1:0]}))
      sb: base_mask = 4'b0001;
      sh: begin
        base_mask    = 4'b0011;
        misaligned_o = (off_i == 2'd3);
      end
      default: begin
        base_mask    = 4'b1111;
        misaligned_o = (off_i != 2'd0);
      end
    endcase
    lane_mask = base_mask << off_i;
    rmask_o   = is_load_i  ? lane_mask : 4'b0000;
    wmask_o   = is_store_i ? lane_mask : 4'b0000;
    wdata_o   = is_store_i ? (rs2_i << {off_i, 3'b000}) : 32'h0;
  end

  always_comb begin
    rdata_shifted = rdata_i >> {off_i, 3'b000};
    extended      = rdata_shifted;
    case (load_funct3_t'(funct3_i))
      lb:      extended = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      lh:      extended = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      lbu:     extended = {24'h0, rdata_shifted[7:0]};
      lhu:     extended = {16'h0, rdata_shifted[15:0]};
      default: extended = rdata_shifted;
    endcase
    mdr_o = is_load_i ? extended : 32'h0;
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: data-memory req/resp access between EX/MEM and MEM/WB buffers.
// Define MEM_STAGE_MISALIGN_TRAP_EN to trap misaligned accesses instead of issuing them.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  rv32i_packet_t   in_packet,
  output logic            in_ready,
  output logic            out_valid,
  output rv32i_packet_t   out_packet,
  input  logic            out_ready,
  output logic            data_mem_read,
  output logic            data_mem_write,
  output logic [XLEN-1:0] data_mem_address,
  output logic [XLEN-1:0] data_mem_wdata,
  output logic [3:0]      data_mem_byte_enable,
  input  logic [XLEN-1:0] data_mem_rdata,
  input  logic            data_mem_resp
);

  if (XLEN != 32) begin : g_xlen_check
    $error("mem_stage supports XLEN == 32 only");
  end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  mem_stage_state_t state_q;
  rv32i_packet_t    req_pkt_q;
  rv32i_packet_t    out_packet_q;
  logic             out_valid_q;
  logic             read_q;
  logic             write_q;
  logic [XLEN-1:0]  address_q;
  logic [XLEN-1:0]  wdata_q;
  logic [3:0]       byte_enable_q;

  rv32i_packet_t    align_src;
  rv32i_packet_t    pkt_d;
  rv32i_packet_t    resp_pkt_d;
  logic             trap_d;
  logic             accept;
  logic             go_req;
  logic             go_direct;
  logic             resp_done;
  logic [3:0]       rmask;
  logic [3:0]       wmask;
  logic [31:0]      wdata;
  logic [31:0]      mdr;
  logic             misaligned;

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign go_req    = accept && in_packet.ctrl.mem && !trap_d;
  assign go_direct = accept && !go_req;
  assign resp_done = (state_q == REQ) && data_mem_resp;

  // No accept can happen in REQ, so one aligner serves both the incoming and the held packet.
  assign align_src = (state_q == REQ) ? req_pkt_q : in_packet;

  mem_align u_align (
    .funct3_i     (align_src.ctrl.funct3),
    .is_load_i    (align_src.ctrl.mem && align_src.ctrl.data_mem_read),
    .is_store_i   (align_src.ctrl.mem && align_src.ctrl.data_mem_write),
    .off_i        (align_src.alu_out[1:0]),
    .rs2_i        (align_src.rs2_out),
    .rdata_i      (data_mem_rdata),
    .rmask_o      (rmask),
    .wmask_o      (wmask),
    .wdata_o      (wdata),
    .mdr_o        (mdr),
    .misaligned_o (misaligned)
  );

  always_comb begin
    trap_d           = TrapEn && in_packet.ctrl.mem && misaligned;
    pkt_d            = in_packet;
    pkt_d.mem_addr   = {in_packet.alu_out[31:2], 2'b00};
    pkt_d.rmask      = rmask;
    pkt_d.wmask      = wmask;
    pkt_d.mem_wdata  = wdata;
    pkt_d.mem_rdata  = 32'h0;
    pkt_d.mdrreg_out = 32'h0;
    if (trap_d) begin
      pkt_d.inst.trap = 1'b1;
      pkt_d.rmask     = 4'b0000;
      pkt_d.wmask     = 4'b0000;
      pkt_d.mem_wdata = 32'h0;
    end
  end

  always_comb begin
    resp_pkt_d = req_pkt_q;
    if (req_pkt_q.ctrl.data_mem_read) begin
      resp_pkt_d.mem_rdata  = data_mem_rdata;
      resp_pkt_d.mdrreg_out = mdr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      req_pkt_q     <= '0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      address_q     <= '0;
      wdata_q       <= '0;
      byte_enable_q <= 4'b0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (go_req) begin
            state_q       <= REQ;
            req_pkt_q     <= pkt_d;
            read_q        <= in_packet.ctrl.data_mem_read;
            write_q       <= in_packet.ctrl.data_mem_write;
            address_q     <= pkt_d.mem_addr;
            wdata_q       <= pkt_d.mem_wdata;
            byte_enable_q <= in_packet.ctrl.data_mem_read ? pkt_d.rmask : pkt_d.wmask;
          end
        end
        REQ: begin
          if (data_mem_resp) begin
            state_q <= IDLE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      out_packet_q <= '0;
    end else if (resp_done) begin
      out_valid_q  <= 1'b1;
      out_packet_q <= resp_pkt_d;
    end else if (go_direct) begin
      out_valid_q  <= 1'b1;
      out_packet_q <= pkt_d;
    end else if (out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign out_valid            = out_valid_q;
  assign out_packet           = out_packet_q;
  assign data_mem_read        = read_q;
  assign data_mem_write       = write_q;
  assign data_mem_address     = address_q;
  assign data_mem_wdata       = wdata_q;
  assign data_mem_byte_enable = byte_enable_q;

  // Decode never sets both directions on one memory op.
  a_no_read_and_write : assert property (@(posedge clk) disable iff (!rst)
    !(accept && in_packet.ctrl.mem && in_packet.ctrl.data_mem_read && in_packet.ctrl.data_mem_write));

endmodule
